// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: circular FIFO of fetched instructions between fetch and decode.
//   Fetch side : enq_valid_i / enq_ready_o handshake carrying pc, inst and prediction.
//   Decode side: head entry on inst1_o/pc_o/pred_*_o; advances when deq_valid_o & ~stall_ID.
//   kill_IF flushes everything at the next edge; reset_i is async active-low.
//   count_o reports the number of valid entries.
module inst_fetch_queue #(
  parameter int DEPTH    = 4,
  parameter int ADDR_LEN = 32,
  parameter int INSN_LEN = 32,
  parameter int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enq_valid_i,
  output logic                enq_ready_o,
  input  logic [ADDR_LEN-1:0] enq_pc_i,
  input  logic [INSN_LEN-1:0] enq_inst_i,
  input  logic                enq_pred_taken_i,
  input  logic [ADDR_LEN-1:0] enq_pred_addr_i,
  input  logic                kill_IF,
  input  logic                stall_ID,
  output logic                deq_valid_o,
  output logic [INSN_LEN-1:0] inst1_o,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic                pred_taken_o,
  output logic [ADDR_LEN-1:0] pred_addr_o,
  output logic [CNT_W-1:0]    count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_LEN-1:0] pc_mem [DEPTH];
  logic [INSN_LEN-1:0] inst_mem [DEPTH];
  logic                pt_mem [DEPTH];
  logic [ADDR_LEN-1:0] pa_mem [DEPTH];
  logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                enq_fire, deq_fire;
  // ready/valid depend only on registered count: no stall_ID-to-ready path
  assign enq_ready_o = count_q != CNT_W'(DEPTH);
  assign deq_valid_o = count_q != '0;
  assign count_o     = count_q;
  assign enq_fire    = enq_valid_i & enq_ready_o & ~kill_IF;
  assign deq_fire    = deq_valid_o & ~stall_ID;
  // empty queue presents a bubble (addi x0,x0,0) so decode never sees garbage
  assign inst1_o      = deq_valid_o ? inst_mem[head_q] : INSN_LEN'(32'h0000_0013);
  assign pc_o         = deq_valid_o ? pc_mem[head_q] : '0;
  assign pred_taken_o = deq_valid_o & pt_mem[head_q];
  assign pred_addr_o  = deq_valid_o ? pa_mem[head_q] : '0;
  always_comb begin
    head_d  = kill_IF ? '0 : head_q + PW'(deq_fire);
    tail_d  = kill_IF ? '0 : tail_q + PW'(enq_fire);
    count_d = kill_IF ? '0 : count_q + CNT_W'(enq_fire) - CNT_W'(deq_fire);
  end
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (enq_fire) begin
      pc_mem[tail_q]   <= enq_pc_i;
      inst_mem[tail_q] <= enq_inst_i;
      pt_mem[tail_q]   <= enq_pred_taken_i;
      pa_mem[tail_q]   <= enq_pred_addr_i;
    end
  end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch queue between the fetch stage and the decode stage (`IDUnit`). It buffers fetched instructions with their PC and branch-prediction info in a small circular FIFO. It presents the oldest entry to decode on `inst1_o` and advances when decode is not stalled. It decouples fetch from decode back-pressure and flushes on `kill_IF`.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `ADDR_LEN`, 32: PC / predicted-address width.
- `INSN_LEN`, 32: instruction width.
- `CNT_W`, $clog2(DEPTH)+1: width of `count_o`.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `reset_i`  in  1  reset, asynchronous, active-low.
- `enq_valid_i`  in  1  fetch presents an instruction.
- `enq_ready_o`  out  1  queue can accept; equals not-full.
- `enq_pc_i`  in  ADDR_LEN  PC of the fetched instruction.
- `enq_inst_i`  in  INSN_LEN  fetched instruction.
- `enq_pred_taken_i`  in  1  branch predicted taken.
- `enq_pred_addr_i`  in  ADDR_LEN  predicted target.
- `kill_IF`  in  1  synchronous flush of all entries.
- `stall_ID`  in  1  decode cannot consume this cycle.
- `deq_valid_o`  out  1  head entry valid.
- `inst1_o`  out  INSN_LEN  head instruction; drives `IDUnit.inst1_i`.
- `pc_o`  out  ADDR_LEN  head PC.
- `pred_taken_o`  out  1  head prediction.
- `pred_addr_o`  out  ADDR_LEN  head predicted target.
- `count_o`  out  CNT_W  number of valid entries (0..DEPTH).

## Operation
- Storage: DEPTH entries of {pc, inst, pred_taken, pred_addr}, a head pointer, a tail pointer (each $clog2(DEPTH) bits, wrapping modulo DEPTH) and a count register.
- Enqueue fire: `enq_valid_i & enq_ready_o`. The entry is written at tail and tail increments.
- Dequeue fire: `deq_valid_o & ~stall_ID`. Head increments.
- `enq_ready_o = (count != DEPTH)`. It depends only on state; there is no combinational path from `stall_ID`. A full queue refuses enqueue even if a dequeue fires the same cycle.
- `deq_valid_o = (count != 0)`. There is no empty bypass: an enqueued instruction is never visible in the same cycle.
- Head outputs are combinational reads of the head entry when `deq_valid_o` = 1.
- When empty, the outputs are forced to bubble values so decode sees a legal no-op:
  - `inst1_o` = 32'h0000_0013 (addi x0,x0,0)
  - `pc_o` = 0
  - `pred_taken_o` = 0
  - `pred_addr_o` = 0
- Count update:
  - enq only: +1
  - deq only: −1
  - both, or neither: unchanged
- `kill_IF` priority:
  - `kill_IF` overrides enqueue and dequeue in the same cycle.
  - Next edge: head = tail = 0, count = 0.
  - A same-cycle enqueue is discarded.
- Reset (async, `reset_i` = 0):
  - Pointers and count clear immediately.
  - All outputs take their empty values: `deq_valid_o` = 0, `enq_ready_o` = 1, `count_o` = 0, bubble `inst1_o`.
  - Entry storage needs no reset.
  - Reset mid-operation discards all contents.

## Timing
- Enqueue at edge N: the entry is at the head output after edge N when the queue was empty. Minimum fetch-to-decode-input latency is 1 cycle.
- Throughput: 1 enqueue and 1 dequeue per cycle, sustained, when neither full nor empty.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble.
- Full with `stall_ID` = 0: the dequeue fires, `enq_ready_o` rises the next cycle, and the next enqueue follows.
- `stall_ID` held: head outputs are stable; the contents of held entries never change.
- Recovery after `kill_IF`: the first post-flush enqueue is accepted the same cycle `kill_IF` deasserts, and appears at the head one cycle later.

## Test plan
- Reset: assert `reset_i` = 0 asynchronously mid-cycle.
  - Outputs immediately show `count_o` = 0, `deq_valid_o` = 0, `enq_ready_o` = 1, `inst1_o` = 32'h00000013.
- Single pass: with `stall_ID` = 0, enqueue pc=0x100, inst=0x00500093.
  - Next cycle: `deq_valid_o` = 1, `inst1_o` = 0x00500093, `pc_o` = 0x100.
  - Following cycle: empty again.
- Fill: with `stall_ID` = 1, enqueue pc 0x0, 0x4, 0x8, 0xC.
  - `count_o` reaches 4 and `enq_ready_o` = 0; a 5th enqueue is ignored.
  - Release `stall_ID`: the outputs stream 0x0, 0x4, 0x8, 0xC in order, one per cycle.
- Wrap and simultaneity: stream 10 enqueues with continuous dequeue.
  - `count_o` holds at 1 after the first.
  - PCs exit in order across two pointer wraps with no bubble.
- Kill: with 3 entries held, assert `kill_IF` together with `enq_valid_i` (pc=0x200).
  - Next cycle: `count_o` = 0 and the 0x200 entry is absent.
  - Enqueue pc=0x300: it appears as the head one cycle later.
- Full plus dequeue: in the same cycle, the queue is full, `stall_ID` = 0 and `enq_valid_i` = 1.
  - The enqueue is not accepted; `count_o` = 3 next cycle.
  - The enqueue is accepted the following cycle.
